// File: rtl/avr_serial_pkg.sv
// rtl/avr_serial_pkg.sv - shared types and defaults for the AVR serial link
package avr_serial_pkg;

    // PARITY stays in the enum even when unused so tx and rx share one encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int AVR_CLK_PER_BIT_DEFAULT = 100;

endpackage

// File: rtl/avr_tx_fifo.sv
// rtl/avr_tx_fifo.sv - byte FIFO feeding the AVR serial transmitter
import avr_serial_pkg::*;

module avr_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [7:0]             i_data,
    input  logic                   i_pop,
    output logic [7:0]             o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          r_full;
    logic          r_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Empty lags occupancy by one cycle so a fresh entry settles before it is read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (r_count == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/avr_serial_tx.sv
// rtl/avr_serial_tx.sv - buffered UART transmitter to the AVR with busy flow control
// Define AVR_TX_PARITY_EN for 8E1 frames; default build sends 8N1.
import avr_serial_pkg::*;

module avr_serial_tx #(
    parameter int CLK_PER_BIT = AVR_CLK_PER_BIT_DEFAULT,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic                   avr_rx_busy,
    output logic                   tx,
    output logic                   tx_active,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [BW-1:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_busy_s1;
    logic        r_busy_s2;
    logic        w_baud_tick;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_fifo_data;
`ifdef AVR_TX_PARITY_EN
    logic        r_parity;
`endif

    avr_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (data_valid),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign data_ready  = !w_full;
    assign w_baud_tick = (r_baud == BAUD_LAST);
    assign w_pop       = (r_state == ST_IDLE) && !w_empty && !r_busy_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_pop) w_state_next = ST_START;
            ST_START:  if (w_baud_tick) w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_baud_tick && (r_bit_idx == 3'd7)) begin
`ifdef AVR_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef AVR_TX_PARITY_EN
            ST_PARITY: if (w_baud_tick) w_state_next = ST_STOP;
`endif
            ST_STOP:   if (w_baud_tick) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx        = 1'b1;
        tx_active = (r_state != ST_IDLE);
        case (r_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
`ifdef AVR_TX_PARITY_EN
            ST_PARITY: tx = r_parity;
`endif
            default:   tx = 1'b1;
        endcase
    end

    // Busy is only ever consulted through the second synchronizer stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_s1 <= 1'b0;
            r_busy_s2 <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef AVR_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_busy_s1 <= avr_rx_busy;
            r_busy_s2 <= r_busy_s1;
            if (r_state == ST_IDLE) begin
                r_baud <= '0;
            end else if (w_baud_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_bit_idx <= '0;
`ifdef AVR_TX_PARITY_EN
                r_parity  <= ^w_fifo_data;
`endif
            end else if ((r_state == ST_DATA) && w_baud_tick) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_avr_serial_tx.sv
// tb/tb_avr_serial_tx.sv - directed self-checking bench for avr_serial_tx
module tb_avr_serial_tx;

    localparam int CPB = 4;
`ifdef AVR_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       avr_rx_busy;
    logic       tx;
    logic       tx_active;
    logic [2:0] fifo_count;

    int tests;
    int fails;

    avr_serial_tx #(
        .CLK_PER_BIT (CPB),
        .DEPTH       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .avr_rx_busy (avr_rx_busy),
        .tx          (tx),
        .tx_active   (tx_active),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bitval(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef AVR_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_start(input string tag, input int limit, output int waited);
        waited = 0;
        while ((tx !== 1'b0) && (waited < limit)) begin
            tick();
            waited++;
        end
        check(tag, tx, 1'b0);
    endtask

    // Starts on the first start-bit sample; ends on the idle cycle after the stop bit.
    task automatic capture_frame(input logic [7:0] b, input string tag, input int busy_at);
        logic [63:0] obs;
        logic [63:0] exp;
        obs = '0;
        exp = '0;
        for (int i = 0; i < FL; i++) begin
            obs[i] = tx;
            exp[i] = bitval(b, i / CPB);
            if (i == FL - 1) check({tag, "_active_end"}, tx_active, 1'b1);
            if (i == busy_at) avr_rx_busy = 1'b1;
            tick();
        end
        check({tag, "_bits"}, obs, exp);
        check({tag, "_len"}, {tx_active, tx}, 2'b01);
    endtask

    initial begin
        int waited;
        int bad;
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        avr_rx_busy = 1'b0;

        // reset then idle
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_tx", tx, 1'b1);
        check("rst_ready", data_ready, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        check("rst_active", tx_active, 1'b0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if ({tx, tx_active, data_ready, fifo_count} !== 6'b101000) bad++;
            tick();
        end
        check("idle_50", bad, 0);

        // single byte latency and frame
        data_in = 8'hA5; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("a5_n_count", fifo_count, 3'd1);
        check("a5_n_tx", tx, 1'b1);
        tick();
        check("a5_n1_tx", {tx, tx_active}, 2'b10);
        tick();
        check("a5_n2_tx", {tx, tx_active}, 2'b01);
        check("a5_n2_count", fifo_count, 3'd0);
        capture_frame(8'hA5, "a5", -1);

        // fill to full while held off, fifth byte dropped
        avr_rx_busy = 1'b1;
        tick(); tick(); tick();
        for (int k = 1; k <= 5; k++) begin
            data_in = 8'(k); data_valid = 1'b1;
            tick();
            if (k <= 4) check($sformatf("fill_ready_%0d", k), data_ready, (k < 4) ? 1'b1 : 1'b0);
        end
        data_valid = 1'b0;
        check("fill_count", fifo_count, 3'd4);
        check("fill_ready_full", data_ready, 1'b0);
        tick(); tick();
        check("fill_held_tx", {tx, tx_active}, 2'b10);
        avr_rx_busy = 1'b0;
        wait_start("fill_start", 8, waited);
        check("fill_count_pop1", fifo_count, 3'd3);
        check("fill_ready_pop1", data_ready, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            capture_frame(8'(k), $sformatf("b2b_%0d", k), -1);
            tick();
            if (k < 4) check($sformatf("b2b_gap_%0d", k), tx, 1'b0);
        end
        check("b2b_count", fifo_count, 3'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx !== 1'b1) bad++;
            tick();
        end
        check("drop_no_frame", bad, 0);

        // busy mid-frame: frame completes, next held until busy falls
        for (int k = 0; k < 2; k++) begin
            data_in = (k == 0) ? 8'h11 : 8'h22; data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        wait_start("b11_start", 5, waited);
        capture_frame(8'h11, "b11", 12);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if ({tx, tx_active} !== 2'b10) bad++;
            tick();
        end
        check("busy_hold", bad, 0);
        check("busy_hold_count", fifo_count, 3'd1);
        avr_rx_busy = 1'b0;
        wait_start("b22_start", 6, waited);
        check("b22_latency_le3", (waited <= 3), 1'b1);
        capture_frame(8'h22, "b22", -1);

        // reset mid-frame truncates and flushes
        for (int k = 0; k < 3; k++) begin
            data_in = (k == 0) ? 8'h3C : ((k == 1) ? 8'h44 : 8'h55); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        wait_start("r3c_start", 3, waited);
        for (int i = 0; i < 12; i++) tick();
        check("r3c_bit2", tx, 1'b1);
        check("r3c_queued", fifo_count, 3'd2);
        rst = 1'b1;
        tick();
        check("rmid_tx", tx, 1'b1);
        check("rmid_count", fifo_count, 3'd0);
        check("rmid_active", tx_active, 1'b0);
        check("rmid_ready", data_ready, 1'b1);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if ({tx, tx_active} !== 2'b10) bad++;
            tick();
        end
        check("rmid_no_frame", bad, 0);

`ifdef AVR_TX_PARITY_EN
        data_in = 8'h07; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        wait_start("p07_start", 5, waited);
        capture_frame(8'h07, "p07", -1);
        data_in = 8'h03; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        wait_start("p03_start", 5, waited);
        capture_frame(8'h03, "p03", -1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
